// File: rtl/ifetch_queue.sv
// Fetch stage: issues imem reads from pc and buffers returned words for decode.
// Define IFQ_BYPASS_EN to forward a response straight to decode when the queue is empty.
module ifetch_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] pc,
  input  logic          fetch_en,
  output logic          pc_stall,
  input  logic          flush,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic [DW-1:0] imem_rdata,
  output logic          id_valid,
  input  logic          id_ready,
  output logic [DW-1:0] id_instr,
  output logic [AW-1:0] id_pc,
  output logic [AW-1:0] id_pc_inc
);

  localparam int PW = $clog2(DEPTH);

  logic [PW:0]   count;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          inflight;
  logic [AW-1:0] inflight_pc;
  logic [DW-1:0] q_instr [DEPTH];
  logic [AW-1:0] q_pc    [DEPTH];

  logic [PW+1:0] used;
  logic          space;
  logic          accept;
  logic          resp;
  logic          byp;
  logic          push;
  logic          pop;

  // credit counts the in-flight read so a response always finds a slot
  assign used   = {1'b0, count} + {{(PW+1){1'b0}}, inflight};
  assign space  = used < (PW+2)'(DEPTH);
  assign accept = fetch_en & ~flush & ~rst & space;

  assign imem_req  = accept;
  assign imem_addr = pc;
  assign pc_stall  = fetch_en & ~flush & ~rst & ~space;

  assign resp = inflight & ~flush & ~rst;

`ifdef IFQ_BYPASS_EN
  assign byp = resp & (count == '0);
`else
  assign byp = 1'b0;
`endif

  assign push = resp & ~(byp & id_ready);
  assign pop  = (count != '0) & id_ready & ~flush & ~rst;

  assign id_valid  = (count != '0) | byp;
  assign id_instr  = byp ? imem_rdata  : q_instr[rd_ptr];
  assign id_pc     = byp ? inflight_pc : q_pc[rd_ptr];
  assign id_pc_inc = id_pc + AW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_instr[i] <= '0;
        q_pc[i]    <= '0;
      end
    end else if (flush) begin
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= accept;
      if (accept)
        inflight_pc <= pc;
      if (push) begin
        q_instr[wr_ptr] <= imem_rdata;
        q_pc[wr_ptr]    <= inflight_pc;
        wr_ptr          <= wr_ptr + PW'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: reset, streaming, full, flush, wrap, bypass.
// Memory model returns 0xA000_0000 + addr one cycle after each request.
module tb_ifetch_queue;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int DEPTH = 4;
`ifdef IFQ_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] pc = '0;
  logic          fetch_en = 1'b0;
  logic          pc_stall;
  logic          flush = 1'b0;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_rdata = '0;
  logic          id_valid;
  logic          id_ready = 1'b0;
  logic [DW-1:0] id_instr;
  logic [AW-1:0] id_pc;
  logic [AW-1:0] id_pc_inc;

  int   vectors = 0;
  int   miscompares = 0;
  logic dead = 1'b0;

  ifetch_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .pc(pc), .fetch_en(fetch_en),
    .pc_stall(pc_stall), .flush(flush), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr),
    .id_pc(id_pc), .id_pc_inc(id_pc_inc)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    imem_rdata <= dead ? 32'h0000_DEAD
                : (imem_req ? 32'hA000_0000 + imem_addr : 32'h0);

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; fetch_en = 1'b1; pc = 32'h10; id_ready = 1'b0;
    next_cycle();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      vectors++;
      if (imem_req !== 1'b0) begin
        miscompares++;
        $display("FAIL rst_req: got %0b expected 0", imem_req);
      end
      vectors++;
      if (pc_stall !== 1'b0) begin
        miscompares++;
        $display("FAIL rst_stall: got %0b expected 0", pc_stall);
      end
      vectors++;
      if (id_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL rst_valid: got %0b expected 0", id_valid);
      end
      vectors++;
      if (id_pc_inc !== 32'h1 || id_pc !== 32'h0 || id_instr !== 32'h0) begin
        miscompares++;
        $display("FAIL rst_head: got pc %0h inc %0h instr %0h expected 0 1 0",
                 id_pc, id_pc_inc, id_instr);
      end
      next_cycle();
    end
    rst = 1'b0; fetch_en = 1'b0;
    next_cycle();
  endtask

  task automatic test_stream;
    logic [AW-1:0] ep;
    for (int k = 0; k <= 10; k++) begin
      pc = AW'(k); fetch_en = (k < 8); id_ready = 1'b1;
      @(negedge clk);
      if (k < 8) begin
        vectors++;
        if (imem_req !== 1'b1 || pc_stall !== 1'b0) begin
          miscompares++;
          $display("FAIL stream_req k=%0d: got req %0b stall %0b expected 1 0",
                   k, imem_req, pc_stall);
        end
      end
      vectors++;
      if (id_valid !== (k >= LAT && k < 8 + LAT)) begin
        miscompares++;
        $display("FAIL stream_valid k=%0d: got %0b expected %0b",
                 k, id_valid, (k >= LAT && k < 8 + LAT));
      end
      if (k >= LAT && k < 8 + LAT) begin
        ep = AW'(k - LAT);
        vectors++;
        if (id_pc !== ep || id_instr !== 32'hA000_0000 + ep) begin
          miscompares++;
          $display("FAIL stream_data k=%0d: got %0h/%0h expected %0h/%0h",
                   k, id_pc, id_instr, ep, 32'hA000_0000 + ep);
        end
      end
      next_cycle();
    end
    fetch_en = 1'b0;
  endtask

  task automatic test_full;
    logic          er, es, ev;
    logic [AW-1:0] ep;
    for (int c = 0; c <= 11; c++) begin
      pc = (c < 4) ? AW'(c) : 32'h4;
      fetch_en = (c <= 7);
      id_ready = (c >= 6);
      er = (c < 4) || (c == 7);
      es = (c >= 4 && c <= 6);
      ev = (c >= LAT && c <= 10);
      ep = (c < 6) ? 32'h0 : AW'(c - 6);
      @(negedge clk);
      vectors++;
      if (imem_req !== er || pc_stall !== es) begin
        miscompares++;
        $display("FAIL full_credit c=%0d: got req %0b stall %0b expected %0b %0b",
                 c, imem_req, pc_stall, er, es);
      end
      vectors++;
      if (id_valid !== ev) begin
        miscompares++;
        $display("FAIL full_valid c=%0d: got %0b expected %0b", c, id_valid, ev);
      end
      if (ev) begin
        vectors++;
        if (id_pc !== ep || id_instr !== 32'hA000_0000 + ep) begin
          miscompares++;
          $display("FAIL full_order c=%0d: got %0h/%0h expected %0h/%0h",
                   c, id_pc, id_instr, ep, 32'hA000_0000 + ep);
        end
      end
      next_cycle();
    end
    fetch_en = 1'b0; id_ready = 1'b0;
  endtask

  task automatic test_flush;
    id_ready = 1'b0;
    for (int c = 0; c <= 8; c++) begin
      flush = (c == 4);
      dead = (c == 3);
      id_ready = (c >= 5);
      fetch_en = (c <= 5);
      pc = (c <= 3) ? AW'(4 + c) : ((c == 4) ? 32'h8 : 32'h40);
      @(negedge clk);
      if (c == 3) begin
        vectors++;
        if (imem_req !== 1'b1 || id_valid !== 1'b1 || id_pc !== 32'h4) begin
          miscompares++;
          $display("FAIL flush_pre: got req %0b valid %0b pc %0h expected 1 1 4",
                   imem_req, id_valid, id_pc);
        end
      end
      if (c == 4) begin
        vectors++;
        if (imem_req !== 1'b0 || pc_stall !== 1'b0) begin
          miscompares++;
          $display("FAIL flush_cycle: got req %0b stall %0b expected 0 0",
                   imem_req, pc_stall);
        end
      end
      if (c == 5) begin
        vectors++;
        if (id_valid !== 1'b0 || imem_req !== 1'b1) begin
          miscompares++;
          $display("FAIL flush_after: got valid %0b req %0b expected 0 1",
                   id_valid, imem_req);
        end
      end
      if (c == 5 + LAT) begin
        vectors++;
        if (id_valid !== 1'b1 || id_pc !== 32'h40 || id_instr !== 32'hA000_0040) begin
          miscompares++;
          $display("FAIL flush_redirect: got %0b %0h/%0h expected 1 40/a0000040",
                   id_valid, id_pc, id_instr);
        end
      end
      if (c >= 5 && id_valid === 1'b1) begin
        vectors++;
        if (id_instr === 32'h0000_DEAD) begin
          miscompares++;
          $display("FAIL flush_drop c=%0d: got %0h expected not dead", c, id_instr);
        end
      end
      if (c == 8) begin
        vectors++;
        if (id_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL flush_end: got %0b expected 0", id_valid);
        end
      end
      next_cycle();
    end
    flush = 1'b0; dead = 1'b0; fetch_en = 1'b0; id_ready = 1'b0;
  endtask

  task automatic test_wrap;
    logic [AW-1:0] base = 32'hFFFF_FFF8;
    logic [AW-1:0] ep;
    int nxt = 0;
    int got = 0;
    for (int cyc = 0; cyc < 80 && got < 9; cyc++) begin
      pc = base + AW'(nxt);
      fetch_en = (nxt < 9);
      id_ready = (cyc % 2 == 0);
      @(negedge clk);
      if (imem_req === 1'b1)
        nxt++;
      if (id_valid === 1'b1 && id_ready) begin
        ep = base + AW'(got);
        vectors++;
        if (id_pc !== ep || id_instr !== 32'hA000_0000 + ep ||
            id_pc_inc !== ep + 32'h1) begin
          miscompares++;
          $display("FAIL wrap_order #%0d: got %0h/%0h/%0h expected %0h/%0h/%0h",
                   got, id_pc, id_instr, id_pc_inc,
                   ep, 32'hA000_0000 + ep, ep + 32'h1);
        end
        got++;
      end
      next_cycle();
    end
    vectors++;
    if (got !== 9) begin
      miscompares++;
      $display("FAIL wrap_count: got %0d expected 9", got);
    end
    fetch_en = 1'b0; id_ready = 1'b0;
    next_cycle();
    next_cycle();
  endtask

`ifdef IFQ_BYPASS_EN
  task automatic test_bypass;
    pc = 32'h20; fetch_en = 1'b1; id_ready = 1'b1;
    next_cycle();
    fetch_en = 1'b0;
    @(negedge clk);
    vectors++;
    if (id_valid !== 1'b1 || id_pc !== 32'h20 || id_instr !== 32'hA000_0020) begin
      miscompares++;
      $display("FAIL bypass_fwd: got %0b %0h/%0h expected 1 20/a0000020",
               id_valid, id_pc, id_instr);
    end
    next_cycle();
    @(negedge clk);
    vectors++;
    if (id_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL bypass_nopush: got %0b expected 0", id_valid);
    end
    next_cycle();
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_full();
    test_flush();
    test_wrap();
`ifdef IFQ_BYPASS_EN
    test_bypass();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
Instruction fetch stage directly downstream of the program counter. Takes the word address each cycle, issues a read to synchronous instruction memory, and buffers returned instructions with their PC in a small FIFO. Presents them to decode over a valid/ready handshake. Back-pressures the PC stage via pc_stall and discards all fetched and in-flight work on flush (branch/jump redirect).

Parameters:
DEPTH, 4, FIFO entries; power of 2, >= 2
AW, 32, address (PC) width; word-addressed
DW, 32, instruction width

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
pc  in  AW  current word address from PC stage
fetch_en  in  1  pc is valid, fetch requested
pc_stall  out  1  PC stage must hold pc this cycle
flush  in  1  redirect: discard buffered and in-flight fetches
imem_req  out  1  instruction memory read strobe
imem_addr  out  AW  read address; equals pc
imem_rdata  in  DW  read data, valid exactly 1 cycle after imem_req
id_valid  out  1  id_instr/id_pc hold a valid entry
id_ready  in  1  decode accepts entry
id_instr  out  DW  instruction at FIFO head
id_pc  out  AW  PC of head instruction
id_pc_inc  out  AW  id_pc + 1, modulo 2^AW

Behaviour:
- Reset: on rst high at a clock edge, clear count, rd/wr pointers, inflight flag and head data. Outputs after reset: id_valid=0, id_instr=0, id_pc=0, id_pc_inc=1. While rst is high: imem_req=0, pc_stall=0.
- Credit: space = (count + inflight) < DEPTH. Uses registered state only; no combinational path from id_ready to pc_stall or imem_req.
- accept = fetch_en & ~flush & ~rst & space. imem_req = accept. imem_addr = pc (combinational).
- pc_stall = fetch_en & ~flush & ~space. pc_stall=0 whenever flush=1, because PC is being redirected.
- Request stage: on accept, inflight<=1 and inflight_pc<=pc; otherwise inflight<=0.
- Response stage: when inflight=1 and flush=0, push {imem_rdata, inflight_pc} at wr_ptr.
- Latency: pc accepted in cycle N; entry pushed at the end of N+1; id_valid=1 from N+2.
- Throughput: one instruction per cycle sustained when id_ready=1 (DEPTH >= 2).
- Pop: pop = id_valid & id_ready. id_valid = (count != 0). Head outputs are driven from the FIFO at rd_ptr.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Pointers: log2(DEPTH) bits, wrap naturally. count: log2(DEPTH)+1 bits.
- Full: count==DEPTH means space=0, so no request is issued and no overflow is possible. Credit accounting guarantees a response always has a slot.
- Empty: id_valid=0; id_instr/id_pc hold last-read values (don't care).
- Flush (priority over all else except rst):
  - count<=0, pointers<=0, inflight<=0.
  - The response arriving in the flush cycle is dropped.
  - No request is issued in the flush cycle.
  - Any pop in the flush cycle is ignored (decode also discards).
  - The cycle after flush, a fetch at the new pc is accepted normally.
- Reset mid-operation: identical to flush plus clearing head data; in-flight response is discarded.

Optional Feature:
IFQ_BYPASS_EN
- Defined: when count==0, inflight=1 and flush=0, the response is forwarded combinationally: id_valid=1, id_instr=imem_rdata, id_pc=inflight_pc in cycle N+1 (latency 1). If id_ready=1 that cycle, the entry is not written to the FIFO; otherwise it is pushed as normal. Credit rule unchanged.
- Undefined: no bypass; latency fixed at 2 cycles.

Test Plan:
- Reset: rst=1 for 2 cycles with fetch_en=1, pc=0x10 -> imem_req=0, pc_stall=0, id_valid=0, id_pc_inc=1 throughout.
- Streaming: pc=0,1,2,...,7 with fetch_en=1, id_ready=1, imem_rdata=0xA000_0000+addr -> id_valid from cycle 2, id_pc=0..7 in order, id_instr=0xA000_0000..07, pc_stall never asserted (bypass off).
- Full: DEPTH=4, id_ready=0, pc=0..5 -> exactly 4 requests (pc 0..3); pc_stall=1 while pc=4; count=4, no overflow. Then id_ready=1 -> drains pc 0,1,2,3, and pc=4 is fetched next.
- Flush with in-flight: 3 entries buffered plus request pc=7 in flight; flush=1 one cycle with imem_rdata=0xDEAD -> id_valid=0 next cycle, 0xDEAD never appears. Then pc=0x40 -> id_pc=0x40 two cycles later.
- Wrap: push/pop 9 entries through DEPTH=4 with id_ready toggling 1,0,1,... -> order preserved across pointer wrap; id_pc_inc for pc=0xFFFF_FFFF equals 0.
- Bypass (IFQ_BYPASS_EN): empty queue, pc=0x20 accepted in cycle N, id_ready=1 -> id_valid=1, id_pc=0x20 in N+1; count stays 0.
